// File: rtl/fast_circle_fetch.sv
// Fetches the centre pixel and the 16-point radius-3 Bresenham ring around it
// from the image SRAM, hiding the one-cycle read latency behind a fixed 18-cycle fetch.
module fast_circle_fetch #(
    parameter int PIXEL_DEPTH = 8,
    parameter int X_MAX       = 16,
    parameter int Y_MAX       = 16,
    localparam int XW         = $clog2(X_MAX) + 1,
    localparam int YW         = $clog2(Y_MAX) + 1
) (
    input  logic                        clk,
    input  logic                        n_rst,
    input  logic                        req_valid,
    output logic                        req_ready,
    input  logic signed [XW-1:0]        cx,
    input  logic signed [YW-1:0]        cy,
    output logic signed [XW-1:0]        x_addr,
    output logic signed [YW-1:0]        y_addr,
    output logic                        ren,
    input  logic [PIXEL_DEPTH-1:0]      rdat,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [PIXEL_DEPTH-1:0]      center,
    output logic [16*PIXEL_DEPTH-1:0]   ring,
    output logic [1:0]                  state_dbg
);

    // Handshakes: a transfer happens on a rising edge where valid && ready are both high.
    // req_ready is high only in IDLE; out_valid is high only in OUT and holds until out_ready.

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        OUT   = 2'd3
    } state_t;

    state_t state, state_nx;

    logic signed [XW-1:0]   cx_r;
    logic signed [YW-1:0]   cy_r;
    logic [4:0]             idx;
    logic                   tag_valid;
    logic [4:0]             tag_idx;
    logic                   tag_oob;
    logic [PIXEL_DEPTH-1:0] center_r;
    logic [PIXEL_DEPTH-1:0] ring_q [16];

    logic signed [2:0]      off_dx, off_dy;
    logic signed [XW-1:0]   pt_x;
    logic signed [YW-1:0]   pt_y;
    logic                   pt_oob;

    // Index 0 is the centre; 1..16 walk the ring clockwise from 12 o'clock.
    always_comb begin
        off_dx = 3'sd0;
        off_dy = 3'sd0;
        case (idx)
            5'd1:  begin off_dx =  3'sd0; off_dy = -3'sd3; end
            5'd2:  begin off_dx =  3'sd1; off_dy = -3'sd3; end
            5'd3:  begin off_dx =  3'sd2; off_dy = -3'sd2; end
            5'd4:  begin off_dx =  3'sd3; off_dy = -3'sd1; end
            5'd5:  begin off_dx =  3'sd3; off_dy =  3'sd0; end
            5'd6:  begin off_dx =  3'sd3; off_dy =  3'sd1; end
            5'd7:  begin off_dx =  3'sd2; off_dy =  3'sd2; end
            5'd8:  begin off_dx =  3'sd1; off_dy =  3'sd3; end
            5'd9:  begin off_dx =  3'sd0; off_dy =  3'sd3; end
            5'd10: begin off_dx = -3'sd1; off_dy =  3'sd3; end
            5'd11: begin off_dx = -3'sd2; off_dy =  3'sd2; end
            5'd12: begin off_dx = -3'sd3; off_dy =  3'sd1; end
            5'd13: begin off_dx = -3'sd3; off_dy =  3'sd0; end
            5'd14: begin off_dx = -3'sd3; off_dy = -3'sd1; end
            5'd15: begin off_dx = -3'sd2; off_dy = -3'sd2; end
            5'd16: begin off_dx = -3'sd1; off_dy = -3'sd3; end
            default: begin off_dx = 3'sd0; off_dy = 3'sd0; end
        endcase
    end

    assign pt_x   = cx_r + XW'(off_dx);
    assign pt_y   = cy_r + YW'(off_dy);
    assign pt_oob = (int'(pt_x) < 0) || (int'(pt_x) > X_MAX - 1) ||
                    (int'(pt_y) < 0) || (int'(pt_y) > Y_MAX - 1);

    // OOB points keep their slot in the schedule but never reach the SRAM.
    assign ren    = (state == ISSUE) && !pt_oob;
    assign x_addr = ren ? pt_x : '0;
    assign y_addr = ren ? pt_y : '0;

    assign req_ready = (state == IDLE);
    assign out_valid = (state == OUT);
    assign state_dbg = state;
    assign center    = center_r;

    always_comb begin
        ring = '0;
        for (int k = 0; k < 16; k++) begin
            ring[k*PIXEL_DEPTH +: PIXEL_DEPTH] = ring_q[k];
        end
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (req_valid) state_nx = ISSUE;
            ISSUE:   if (idx == 5'd16) state_nx = DRAIN;
            DRAIN:   state_nx = OUT;
            OUT:     if (out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            cx_r      <= '0;
            cy_r      <= '0;
            idx       <= '0;
            tag_valid <= 1'b0;
            tag_idx   <= '0;
            tag_oob   <= 1'b0;
            center_r  <= '0;
            for (int k = 0; k < 16; k++) begin
                ring_q[k] <= '0;
            end
        end else begin
            if (state == IDLE && req_valid) begin
                cx_r <= cx;
                cy_r <= cy;
                idx  <= '0;
            end else if (state == ISSUE && idx != 5'd16) begin
                idx <= idx + 5'd1;
            end

            // Tag each issue slot so the returning rdat lands in the right place a cycle later.
            tag_valid <= (state == ISSUE);
            tag_idx   <= idx;
            tag_oob   <= pt_oob;

            if (tag_valid) begin
                if (tag_idx == 5'd0) begin
                    center_r <= tag_oob ? '0 : rdat;
                end else begin
                    ring_q[4'(tag_idx - 5'd1)] <= tag_oob ? '0 : rdat;
                end
            end
        end
    end

endmodule

// File: tb/tb_fast_circle_fetch.sv
// Directed bench for fast_circle_fetch against an image SRAM holding pixel(x,y) = x + 16*y.
module tb_fast_circle_fetch;

  logic               clk;
  logic               n_rst;
  logic               req_valid;
  logic               req_ready;
  logic signed [4:0]  cx, cy;
  logic signed [4:0]  x_addr, y_addr;
  logic               ren;
  logic [7:0]         rdat;
  logic               out_valid;
  logic               out_ready;
  logic [7:0]         center;
  logic [127:0]       ring;
  logic [1:0]         state_dbg;

  int checks = 0;
  int errors = 0;
  int ren_cnt = 0;
  int issue_cnt = 0;
  int bad_addr = 0;
  int lat;

  logic [7:0]   exp_q[$];
  logic [7:0]   exp_center;
  logic [127:0] exp_ring;

  int dxs[17] = '{0, 0, 1, 2, 3, 3, 3, 2, 1, 0, -1, -2, -3, -3, -3, -2, -1};
  int dys[17] = '{0, -3, -3, -2, -1, 0, 1, 2, 3, 3, 3, 2, 1, 0, -1, -2, -3};

  fast_circle_fetch #(.PIXEL_DEPTH(8), .X_MAX(16), .Y_MAX(16)) dut (
    .clk       (clk),
    .n_rst     (n_rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .cx        (cx),
    .cy        (cy),
    .x_addr    (x_addr),
    .y_addr    (y_addr),
    .ren       (ren),
    .rdat      (rdat),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .center    (center),
    .ring      (ring),
    .state_dbg (state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // image SRAM model and bus monitor
  always @(posedge clk) begin
    if (ren) begin
      rdat <= 8'(int'(x_addr) + 16 * int'(y_addr));
      ren_cnt++;
      if (int'(x_addr) < 0 || int'(x_addr) > 15 || int'(y_addr) < 0 || int'(y_addr) > 15)
        bad_addr++;
    end
    if (state_dbg == 2'd1) issue_cnt++;
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_expected(input int x, input int y);
    for (int k = 0; k < 17; k++) begin
      int px, py;
      px = x + dxs[k];
      py = y + dys[k];
      if (px < 0 || px > 15 || py < 0 || py > 15) exp_q.push_back(8'h00);
      else exp_q.push_back(8'(px + 16 * py));
    end
  endtask

  task automatic start_req(input int x, input int y);
    @(negedge clk);
    chk("req_ready_idle", 128'(req_ready), 128'(1));
    req_valid = 1'b1;
    cx = 5'(x);
    cy = 5'(y);
    push_expected(x, y);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    ren_cnt = 0;
    issue_cnt = 0;
  endtask

  task automatic wait_out(output int n_out);
    n_out = 0;
    for (int n = 1; n <= 60; n++) begin
      @(posedge clk);
      #1;
      if (out_valid) begin
        n_out = n;
        break;
      end
    end
  endtask

  task automatic collect(input int hold);
    chk("sb_depth", 128'(exp_q.size()), 128'(17));
    exp_center = 8'h00;
    exp_ring = '0;
    if (exp_q.size() >= 17) begin
      exp_center = exp_q.pop_front();
      for (int k = 0; k < 16; k++) exp_ring[k*8 +: 8] = exp_q.pop_front();
    end
    for (int h = 0; h <= hold; h++) begin
      @(negedge clk);
      chk("out_valid_hold", 128'(out_valid), 128'(1));
      chk("req_ready_busy", 128'(req_ready), 128'(0));
      chk("center", 128'(center), 128'(exp_center));
      chk("ring", ring, exp_ring);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("idle_after_out", 128'(req_ready), 128'(1));
    chk("out_valid_drop", 128'(out_valid), 128'(0));
  endtask

  initial begin
    int ov_seen;
    n_rst = 1'b0;
    req_valid = 1'b0;
    out_ready = 1'b0;
    cx = '0;
    cy = '0;

    // 1. reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_ready", 128'(req_ready), 128'(1));
    chk("rst_out_valid", 128'(out_valid), 128'(0));
    chk("rst_ren", 128'(ren), 128'(0));
    chk("rst_ring", ring, 128'(0));
    chk("rst_center", 128'(center), 128'(0));
    chk("rst_x_addr", 128'(x_addr), 128'(0));
    @(negedge clk);
    n_rst = 1'b1;

    // 2. interior fetch
    start_req(8, 8);
    wait_out(lat);
    chk("latency_8_8", 128'(lat), 128'(18));
    chk("pt_center", 128'(center), 128'(8'h88));
    chk("pt1", 128'(ring[0*8 +: 8]), 128'(8'h58));
    chk("pt5", 128'(ring[4*8 +: 8]), 128'(8'h8B));
    chk("pt9", 128'(ring[8*8 +: 8]), 128'(8'hB8));
    chk("pt13", 128'(ring[12*8 +: 8]), 128'(8'h85));
    chk("ren_cnt_8_8", 128'(ren_cnt), 128'(17));
    collect(0);

    // 3. corner padding
    start_req(0, 0);
    wait_out(lat);
    chk("latency_0_0", 128'(lat), 128'(18));
    chk("corner_pt5", 128'(ring[4*8 +: 8]), 128'(8'h03));
    chk("corner_pt9", 128'(ring[8*8 +: 8]), 128'(8'h30));
    chk("corner_pt1", 128'(ring[0*8 +: 8]), 128'(8'h00));
    chk("corner_pt16", 128'(ring[15*8 +: 8]), 128'(8'h00));
    chk("corner_issue_cycles", 128'(issue_cnt), 128'(17));
    chk("corner_ren_cnt", 128'(ren_cnt), 128'(6));
    collect(0);

    // 4. backpressure then a back-to-back request
    start_req(5, 10);
    wait_out(lat);
    chk("latency_5_10", 128'(lat), 128'(18));
    collect(10);
    start_req(2, 13);
    wait_out(lat);
    chk("latency_2_13", 128'(lat), 128'(18));
    collect(0);

    // 5. reset in the middle of a fetch
    start_req(9, 4);
    repeat (7) @(posedge clk);
    @(negedge clk);
    n_rst = 1'b0;
    @(posedge clk);
    #1;
    chk("midrst_req_ready", 128'(req_ready), 128'(1));
    chk("midrst_out_valid", 128'(out_valid), 128'(0));
    chk("midrst_ren", 128'(ren), 128'(0));
    chk("midrst_center", 128'(center), 128'(0));
    exp_q.delete();
    @(negedge clk);
    n_rst = 1'b1;
    ov_seen = 0;
    for (int n = 0; n < 30; n++) begin
      @(negedge clk);
      if (out_valid) ov_seen++;
    end
    chk("midrst_no_out_valid", 128'(ov_seen), 128'(0));
    start_req(3, 3);
    wait_out(lat);
    chk("latency_3_3", 128'(lat), 128'(18));
    collect(0);

    chk("sram_addr_in_image", 128'(bad_addr), 128'(0));
    chk("sb_drained", 128'(exp_q.size()), 128'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
